seq_divider: RTL and testbench

- Parametrised iterative restoring divider; successor to the single-cycle divide block in the arithmetic datapath.
- Computes one quotient bit per clock, so wide operands do not create a long combinational divide path.
- Uses an lds/start/busy/done handshake, latched results and divide-by-zero detection.
- Sits between the operand-load controller and the result register file.

---
 rtl/seq_divider.sv | 182 ++++++++++++++++++
 tb/tb_seq_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock; done pulses DW cycles after start (DW+1 with SIGNED_DIV_EN).
// lds/start are ignored while busy; results are held until the next accepted start. Optional macro: SIGNED_DIV_EN.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lds,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          dbz,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] op_a;
  logic [VW-1:0] op_b;
  logic [DW-1:0] q_sh;
  logic [VW:0]   rem_p;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic          idle_ok;
  logic          accept;
  logic [DW-1:0] src_a;
  logic [VW-1:0] src_b;
  logic [DW-1:0] mag_a;
  logic [VW-1:0] mag_b;
  logic          src_zero;

  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;
  logic          qbit;
  logic [VW:0]   rem_nxt;
  logic [DW-1:0] q_nxt;

`ifdef SIGNED_DIV_EN
  logic          neg_q;
  logic          neg_r;
  logic          sat;
  logic [DW-1:0] q_fix;
  logic [VW-1:0] r_fix;
`endif

  assign idle_ok  = (state == IDLE) || (state == DONE);
  assign accept   = start && idle_ok;
  // Operands loaded on the same edge as start are used directly from the ports.
  assign src_a    = (lds && idle_ok) ? dividend : op_a;
  assign src_b    = (lds && idle_ok) ? divisor  : op_b;
  assign src_zero = (src_b == '0);

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  always_comb begin
    mag_a = src_a;
    mag_b = src_b;
`ifdef SIGNED_DIV_EN
    if (src_a[DW-1]) mag_a = -src_a;
    if (src_b[VW-1]) mag_b = -src_b;
`endif
  end

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    shifted = {1'b0, rem_p[VW:0]} << 1;
    shifted[0] = q_sh[DW-1];
    diff    = shifted - {2'b00, dvs};
    qbit    = ~diff[VW+1];
    rem_nxt = qbit ? diff[VW:0] : shifted[VW:0];
    q_nxt   = {q_sh[DW-2:0], qbit};
  end

`ifdef SIGNED_DIV_EN
  always_comb begin
    q_fix = neg_q ? -q_sh : q_sh;
    if (sat) q_fix = {1'b0, {(DW-1){1'b1}}};
    r_fix = neg_r ? -rem_p[VW-1:0] : rem_p[VW-1:0];
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = src_zero ? DONE : RUN;
        else
          state_nxt = IDLE;
      end
      RUN: begin
        if (cnt == '0) begin
`ifdef SIGNED_DIV_EN
          state_nxt = FIX;
`else
          state_nxt = DONE;
`endif
        end
      end
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a      <= '0;
      op_b      <= '0;
      q_sh      <= '0;
      rem_p     <= '0;
      dvs       <= '0;
      cnt       <= '0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SIGNED_DIV_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      sat       <= 1'b0;
`endif
    end else begin
      if (lds && idle_ok) begin
        op_a <= dividend;
        op_b <= divisor;
      end
      if (accept) begin
        if (src_zero) begin
          dbz       <= 1'b1;
          quotient  <= '1;
          remainder <= '0;
        end else begin
          dbz   <= 1'b0;
          q_sh  <= mag_a;
          dvs   <= mag_b;
          rem_p <= '0;
          cnt   <= CW'(DW - 1);
`ifdef SIGNED_DIV_EN
          neg_q <= src_a[DW-1] ^ src_b[VW-1];
          neg_r <= src_a[DW-1];
          sat   <= (src_a == {1'b1, {(DW-1){1'b0}}}) && (src_b == '1);
`endif
        end
      end else if (state == RUN) begin
        q_sh  <= q_nxt;
        rem_p <= rem_nxt;
        cnt   <= cnt - CW'(1);
`ifndef SIGNED_DIV_EN
        if (cnt == '0) begin
          quotient  <= q_nxt;
          remainder <= rem_nxt[VW-1:0];
        end
`endif
      end
`ifdef SIGNED_DIV_EN
      else if (state == FIX) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (DW=8, VW=5); vectors and latency follow SIGNED_DIV_EN when defined.
module tb_seq_divider;

`ifdef SIGNED_DIV_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lds = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [4:0] divisor = '0;
  logic       busy, done, dbz;
  logic [7:0] quotient;
  logic [4:0] remainder;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] prev_q = '0;
  logic [4:0] prev_r = '0;

  seq_divider #(.DW(8), .VW(5)) dut (
    .clk(clk), .rst(rst), .lds(lds), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .dbz(dbz),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [4:0] b;
    bit         tog;
    logic [7:0] q;
    logic [4:0] r;
    bit         z;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else
      pass_cnt++;
  endtask

  // Call at #1 after the start edge; counts edges until done, busy samples, and output hold.
  task automatic wait_done(input int n0, output int n, output int nb, output bit hold_ok);
    n = n0;
    nb = 0;
    hold_ok = 1'b1;
    while (!done && n < 64) begin
      if (busy) nb++;
      if (quotient !== prev_q || remainder !== prev_r) hold_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_op(input string nm, input vec_t v);
    int n, nb;
    bit hold_ok;
    if (!v.tog) begin
      lds = 1'b1; dividend = v.a; divisor = v.b;
      @(posedge clk); #1;
      lds = 1'b0; dividend = 8'h5A; divisor = 5'h0B;
    end else begin
      lds = 1'b1; dividend = v.a; divisor = v.b;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lds = 1'b0;
    wait_done(0, n, nb, hold_ok);
    chk({nm, "_latency"}, n, v.z ? 0 : LAT);
    chk({nm, "_busy_cycles"}, nb, v.z ? 0 : LAT);
    chk({nm, "_hold"}, hold_ok, 1);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_in_done"}, busy, 0);
    chk({nm, "_q"}, quotient, v.q);
    chk({nm, "_r"}, remainder, v.r);
    chk({nm, "_dbz"}, dbz, v.z);
    prev_q = v.q;
    prev_r = v.r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb;
    bit hold_ok, seen;

`ifdef SIGNED_DIV_EN
    vt.push_back('{8'h9C, 5'd7,  1'b0, 8'hF2, 5'h1E, 1'b0});
    vt.push_back('{8'd100, 5'h19, 1'b1, 8'hF2, 5'd2,  1'b0});
    vt.push_back('{8'h9C, 5'h19, 1'b0, 8'd14, 5'h1E, 1'b0});
    vt.push_back('{8'h80, 5'h1F, 1'b1, 8'h7F, 5'd0,  1'b0});
    vt.push_back('{8'd5,  5'd0,  1'b0, 8'hFF, 5'd0,  1'b1});
    vt.push_back('{8'd3,  5'd9,  1'b1, 8'd0,  5'd3,  1'b0});
`else
    vt.push_back('{8'd200, 5'd7,  1'b0, 8'd28,  5'd4, 1'b0});
    vt.push_back('{8'd3,   5'd9,  1'b0, 8'd0,   5'd3, 1'b0});
    vt.push_back('{8'd255, 5'd0,  1'b1, 8'd255, 5'd0, 1'b1});
    vt.push_back('{8'd255, 5'd31, 1'b0, 8'd8,   5'd7, 1'b0});
    vt.push_back('{8'd0,   5'd5,  1'b1, 8'd0,   5'd0, 1'b0});
    vt.push_back('{8'd254, 5'd31, 1'b1, 8'd8,   5'd6, 1'b0});
    vt.push_back('{8'd129, 5'd16, 1'b0, 8'd8,   5'd1, 1'b0});
    vt.push_back('{8'd255, 5'd1,  1'b0, 8'd255, 5'd0, 1'b0});
`endif

    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", dbz, 0);
    chk("reset_q", quotient, 0);
    chk("reset_r", remainder, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      do_op($sformatf("v%0d", i), vt[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Results held through idle cycles
    repeat (5) @(posedge clk);
    #1;
    chk("hold_idle_q", quotient, prev_q);
    chk("hold_idle_r", remainder, prev_r);

    // lds and start while busy are ignored
    lds = 1'b1; start = 1'b1; dividend = 8'd100; divisor = 5'd7;
    @(posedge clk); #1;
    lds = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lds = 1'b1; start = 1'b1; dividend = 8'd10; divisor = 5'd3;
    @(posedge clk); #1;
    lds = 1'b0; start = 1'b0;
    wait_done(4, n, nb, hold_ok);
    chk("busy_ign_latency", n, LAT);
    chk("busy_ign_q", quotient, 14);
    chk("busy_ign_r", remainder, 2);
    prev_q = 8'd14; prev_r = 5'd2;
    @(posedge clk); #1;
    // Restart without reload: operand registers must still hold 100/7
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, n, nb, hold_ok);
    chk("reuse_ops_latency", n, LAT);
    chk("reuse_ops_q", quotient, 14);
    chk("reuse_ops_r", remainder, 2);

    // lds+start in the DONE cycle: no idle gap
    lds = 1'b1; start = 1'b1; dividend = 8'd100; divisor = 5'd10;
    @(posedge clk); #1;
    lds = 1'b0; start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    wait_done(0, n, nb, hold_ok);
    chk("b2b_latency", n, LAT);
    chk("b2b_hold", hold_ok, 1);
    chk("b2b_q", quotient, 10);
    chk("b2b_r", remainder, 0);
    chk("b2b_dbz", dbz, 0);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    lds = 1'b1; start = 1'b1; dividend = 8'd77; divisor = 5'd5;
    @(posedge clk); #1;
    lds = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    #2;
    rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    prev_q = '0; prev_r = '0;
    do_op("post_rst", '{8'd77, 5'd5, 1'b1, 8'd15, 5'd2, 1'b0});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
